// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg : shared constants and FSM encoding for the memory arbiter
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package mem_pkg;
    localparam int W          = 17;
    localparam int AW         = 8;
    localparam int NPORT      = 3;
    localparam int PORT_LD    = 0;
    localparam int PORT_DATA  = 1;
    localparam int PORT_FETCH = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERVE  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;
endpackage

`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2 : combinational two-way round-robin picker (a = data, b = fetch)
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rr_pick2 (
    input  logic       i_req_a,
    input  logic       i_req_b,
    input  logic       i_last_b,
    output logic [1:0] o_gnt
);
    always_comb begin
        o_gnt = 2'b00;
        if (i_req_a && i_req_b) begin
            // On a tie the side not served last wins.
            o_gnt = i_last_b ? 2'b01 : 2'b10;
        end else if (i_req_a) begin
            o_gnt = 2'b01;
        end else if (i_req_b) begin
            o_gnt = 2'b10;
        end
    end
endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter : single-port memory arbiter for loader, data and fetch ports
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
    import mem_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NPORT-1:0]    req_valid,
    input  logic [NPORT-1:0]    req_we,
    input  logic [NPORT*AW-1:0] req_addr,
    input  logic [NPORT*W-1:0]  req_wdata,
    input  logic                ld_lock,
    input  logic [W-1:0]        mem_q,
    output logic [NPORT-1:0]    req_ready,
    output logic [NPORT-1:0]    rsp_valid,
    output logic [W-1:0]        rsp_rdata,
    output logic [AW-1:0]       mem_ad,
    output logic [W-1:0]        mem_data,
    output logic                mem_WE
);
    localparam logic [NPORT-1:0] c_WE_MASK = 3'b011;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rr_last;
    logic [1:0]       w_rr_gnt;
    logic [NPORT-1:0] w_gnt;
    logic [NPORT-1:0] w_we_eff;
    logic             w_hold_lock;
    logic             w_rd_gnt;

    rr_pick2 u_rr_pick2 (
        .i_req_a  (req_valid[PORT_DATA]),
        .i_req_b  (req_valid[PORT_FETCH]),
        .i_last_b (r_rr_last),
        .o_gnt    (w_rr_gnt)
    );

    assign w_we_eff    = req_we & c_WE_MASK;
    assign w_hold_lock = (r_state == ST_LOCKED) && ld_lock;

    always_comb begin
        w_gnt       = '0;
        w_state_nxt = ST_IDLE;
        if (!rst_n) begin
            w_gnt = '0;
        end else if (w_hold_lock) begin
            // Loader owns the memory; an idle loader leaves a bubble.
            w_gnt[PORT_LD] = req_valid[PORT_LD];
        end else if (req_valid[PORT_LD]) begin
            w_gnt[PORT_LD] = 1'b1;
        end else begin
            w_gnt[PORT_FETCH:PORT_DATA] = w_rr_gnt;
        end

        if ((w_gnt[PORT_LD] && ld_lock) || w_hold_lock) begin
            w_state_nxt = ST_LOCKED;
        end else if (|w_gnt) begin
            w_state_nxt = ST_SERVE;
        end
    end

    always_comb begin
        mem_ad   = '0;
        mem_data = '0;
        mem_WE   = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
            if (w_gnt[p]) begin
                mem_ad   = req_addr[p*AW +: AW];
                mem_data = req_wdata[p*W +: W];
                mem_WE   = w_we_eff[p];
            end
        end
    end

    assign req_ready = w_gnt;
    assign w_rd_gnt  = |(w_gnt & ~w_we_eff);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rr_last <= 1'b1;
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            rsp_valid <= w_gnt;
            if (w_rd_gnt) begin
                rsp_rdata <= mem_q;
            end
            if (w_gnt[PORT_DATA]) begin
                r_rr_last <= 1'b0;
            end else if (w_gnt[PORT_FETCH]) begin
                r_rr_last <= 1'b1;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter : directed + randomized bench with a rule-level arbiter model
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mem_arbiter;
    localparam int W  = 17;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    req_valid, req_we;
    logic [3*AW-1:0] req_addr;
    logic [3*W-1:0]  req_wdata;
    logic          ld_lock;
    logic [W-1:0]  mem_q;
    logic [2:0]    req_ready, rsp_valid;
    logic [W-1:0]  rsp_rdata;
    logic [AW-1:0] mem_ad;
    logic [W-1:0]  mem_data;
    logic          mem_WE;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .ld_lock(ld_lock),
        .mem_q(mem_q), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .mem_ad(mem_ad), .mem_data(mem_data),
        .mem_WE(mem_WE)
    );

    always #5 clk = ~clk;

    // Memory instance the arbiter drives: async read, write on rising edge.
    logic [W-1:0] bmem [0:255];
    always @(posedge clk) if (mem_WE) bmem[mem_ad] <= mem_data;
    assign mem_q = bmem[mem_ad];

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit           m_locked;
    bit           m_fetch_last;
    logic [W-1:0] m_mem [0:255];
    logic [2:0]   e_rv;
    logic [W-1:0] e_rd;
    logic [2:0]   obs_g;
    logic         obs_we;
    logic [W-1:0] lock_wd [4];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int p);
        return req_addr[p*AW +: AW];
    endfunction

    function automatic logic [W-1:0] data_of(input int p);
        return req_wdata[p*W +: W];
    endfunction

    function automatic logic [2:0] exp_grant();
        logic [2:0] g;
        g = 3'b000;
        if (!rst_n)                     g = 3'b000;
        else if (m_locked && ld_lock)   g = {2'b00, req_valid[0]};
        else if (req_valid[0])          g = 3'b001;
        else if (req_valid[1] && req_valid[2]) g = m_fetch_last ? 3'b010 : 3'b100;
        else if (req_valid[1])          g = 3'b010;
        else if (req_valid[2])          g = 3'b100;
        return g;
    endfunction

    function automatic int winner(input logic [2:0] g);
        for (int p = 0; p < 3; p++) if (g[p]) return p;
        return -1;
    endfunction

    task automatic set_port(input int p, input bit v, input bit we,
                            input logic [AW-1:0] a, input logic [W-1:0] d);
        req_valid[p] = v;
        req_we[p]    = we;
        req_addr[p*AW +: AW] = a;
        req_wdata[p*W +: W]  = d;
    endtask

    task automatic idle_ports();
        req_valid = 3'b000;
        req_we    = 3'b000;
    endtask

    // One clock: check everything at negedge, then advance the model at posedge.
    task automatic cycle();
        logic [2:0] g;
        int         w;
        logic [AW-1:0] ea;
        logic [W-1:0]  ed;
        logic          ewe;
        @(negedge clk);
        g   = exp_grant();
        w   = winner(g);
        ea  = '0; ed = '0; ewe = 1'b0;
        if (w >= 0) begin
            ea  = addr_of(w);
            ed  = data_of(w);
            ewe = (w != 2) && req_we[w];
        end
        obs_g  = req_ready;
        obs_we = mem_WE;
        chk("req_ready", {14'd0, req_ready}, {14'd0, g});
        chk("mem_WE", {16'd0, mem_WE}, {16'd0, ewe});
        chk("mem_ad", {9'd0, mem_ad}, {9'd0, ea});
        chk("mem_data", mem_data, ed);
        chk("rsp_valid", {14'd0, rsp_valid}, {14'd0, e_rv});
        chk("rsp_rdata", rsp_rdata, e_rd);
        @(posedge clk);
        if (!rst_n) begin
            m_locked = 1'b0; m_fetch_last = 1'b1; e_rv = 3'b000; e_rd = '0;
        end else begin
            e_rv = g;
            if (w >= 0) begin
                if (ewe) m_mem[ea] = ed;
                else     e_rd = m_mem[ea];
                if (w == 1) m_fetch_last = 1'b0;
                if (w == 2) m_fetch_last = 1'b1;
            end
            m_locked = ld_lock && (g[0] || m_locked);
        end
        #1;
    endtask

    initial begin
        logic [2:0] cont_exp [4];
        logic [2:0] lock_exp [5];
        cont_exp = '{3'b010, 3'b100, 3'b010, 3'b100};
        lock_exp = '{3'b001, 3'b001, 3'b000, 3'b001, 3'b001};
        req_addr = '0; req_wdata = '0; idle_ports();
        ld_lock = 1'b0; rst_n = 1'b0;
        m_locked = 1'b0; m_fetch_last = 1'b1; e_rv = 3'b000; e_rd = '0;

        // Reset with every port requesting.
        @(posedge clk); #1;
        for (int p = 0; p < 3; p++) set_port(p, 1'b1, 1'b1, 8'(p + 1), 17'(p + 5));
        cycle();
        chk("rst_ready", {14'd0, obs_g}, 17'd0);
        chk("rst_mem_we", {16'd0, obs_we}, 17'd0);
        cycle();
        rst_n = 1'b1; idle_ports();
        chk("rst_rsp_valid", {14'd0, rsp_valid}, 17'd0);
        chk("rst_rsp_rdata", rsp_rdata, 17'd0);

        // Preload through the loader.
        for (int i = 0; i < 80; i++) begin
            set_port(0, 1'b1, 1'b1, i[7:0], 17'($urandom));
            cycle();
        end
        set_port(0, 1'b1, 1'b1, 8'h0C, 17'h00003);
        cycle();

        // Single fetch read.
        idle_ports();
        set_port(2, 1'b1, 1'b0, 8'h0C, 17'd0);
        cycle();
        chk("single_ready", {14'd0, obs_g}, 17'b100);
        chk("single_rsp_valid", {14'd0, rsp_valid}, 17'b100);
        chk("single_rsp_rdata", rsp_rdata, 17'h00003);

        // Data/fetch contention.
        idle_ports();
        set_port(1, 1'b1, 1'b0, 8'h10, 17'd0);
        set_port(2, 1'b1, 1'b0, 8'h11, 17'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("contend", {14'd0, obs_g}, {14'd0, cont_exp[i]});
        end

        // Loader priority; round-robin pointer must not move.
        set_port(0, 1'b1, 1'b0, 8'h05, 17'd0);
        cycle();
        chk("ld_prio", {14'd0, obs_g}, 17'b001);
        set_port(0, 1'b0, 1'b0, 8'h05, 17'd0);
        cycle();
        chk("rr_kept", {14'd0, obs_g}, 17'b010);

        // Locked burst with a bubble while data/fetch keep requesting.
        ld_lock = 1'b1;
        for (int k = 0, n = 0; k < 5; k++) begin
            if (k == 2) begin
                set_port(0, 1'b0, 1'b0, 8'h00, 17'd0);
            end else begin
                lock_wd[n] = 17'($urandom);
                set_port(0, 1'b1, 1'b1, 8'(8'h20 + n), lock_wd[n]);
                n++;
            end
            cycle();
            chk("lock_grant", {14'd0, obs_g}, {14'd0, lock_exp[k]});
        end
        ld_lock = 1'b0;
        idle_ports();
        set_port(1, 1'b1, 1'b0, 8'h20, 17'd0);
        cycle();
        chk("unlock_data", {14'd0, obs_g}, 17'b010);
        chk("lock_wr_readback", rsp_rdata, lock_wd[0]);

        // Read-after-write, then reset during a granted write.
        idle_ports();
        set_port(1, 1'b1, 1'b1, 8'h40, 17'h1ABCD);
        cycle();
        idle_ports();
        set_port(2, 1'b1, 1'b0, 8'h40, 17'd0);
        cycle();
        chk("raw_rdata", rsp_rdata, 17'h1ABCD);
        idle_ports();
        rst_n = 1'b0;
        set_port(1, 1'b1, 1'b1, 8'h40, 17'h00001);
        cycle();
        chk("rst_write_we", {16'd0, obs_we}, 17'd0);
        chk("rst_write_mem", bmem[8'h40], 17'h1ABCD);
        chk("rst_drop_rsp", {14'd0, rsp_valid}, 17'd0);
        rst_n = 1'b1;
        idle_ports();
        set_port(2, 1'b1, 1'b0, 8'h40, 17'd0);
        cycle();
        chk("post_rst_read", rsp_rdata, 17'h1ABCD);

        // Randomized traffic over a small address window.
        for (int i = 0; i < 400; i++) begin
            rst_n   = ($urandom_range(0, 39) != 0);
            ld_lock = ($urandom_range(0, 2) == 0);
            for (int p = 0; p < 3; p++)
                set_port(p, 1'($urandom), 1'($urandom),
                         8'(8'h40 + $urandom_range(0, 7)), 17'($urandom));
            cycle();
        end
        rst_n = 1'b1; ld_lock = 1'b0; idle_ports();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port arbiter that shares the processor's 256 x 17-bit unified instruction/data memory between three requesters: the program loader, the execute-stage data port (load/store), and the fetch unit. It grants at most one access per cycle, drives the memory's address, write-data and write-enable inputs, and registers read data back to the winning requester. It sits between the core and the memory instance and replaces direct core-to-memory wiring.

## Interface
- W, 17, memory word width
- AW, 8, address width (memory depth 2^AW)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  3  per-port request; bit 0 loader, bit 1 data, bit 2 fetch
- req_we  in  3  per-port write enable (fetch bit ignored, treated as 0)
- req_addr  in  3*AW  packed per-port address, port i at [i*AW +: AW]
- req_wdata  in  3*W  packed per-port write data
- ld_lock  in  1  loader holds the memory across consecutive accesses
- req_ready  out  3  one-hot grant, combinational this cycle
- rsp_valid  out  3  one-hot response, registered, one cycle after grant
- rsp_rdata  out  W  registered read data (valid with rsp_valid, reads only)
- mem_ad  out  AW  memory address
- mem_data  out  W  memory write data
- mem_WE  out  1  memory write enable

## Operation
- Memory read is combinational, write lands on the rising edge; the arbiter adds one register stage on the response.
- FSM states: IDLE, SERVE, LOCKED.
  - IDLE: no grant last cycle. Any valid request -> SERVE (or LOCKED if loader wins with ld_lock=1).
  - SERVE: granted last cycle. Continue arbitrating; no valid request -> IDLE.
  - LOCKED: loader owns memory; only port 0 may be granted, even when req_valid[0]=0 (lock bubble). ld_lock=0 -> re-arbitrate this cycle as in SERVE.
- Priority outside LOCKED: loader highest, fixed. Data and fetch alternate round-robin; rr_last bit records the last of the two granted. On a data/fetch tie, the one not granted last wins. rr_last updates only on data/fetch grants.
- Grant cycle: mem_ad = winner address; mem_data = winner wdata; mem_WE = winner req_we AND grant. With no grant, mem_WE = 0 and mem_ad/mem_data = 0.
- Next edge: rsp_valid = registered grant vector. rsp_rdata = memory read value captured from mem_ad; on write grants it holds its previous value.
- A request is consumed when req_valid & req_ready are both high. A requester keeps valid/addr/we/wdata stable until ready.

## Timing
- Reset (rst_n=0 at edge): state IDLE, rr_last = fetch (data wins the first tie), rsp_valid = 0, rsp_rdata = 0. req_ready and mem_WE are 0 while rst_n=0.
- Reset mid-transfer drops any pending response: rsp_valid is 0 the cycle after reset is sampled. A write granted in the reset cycle is suppressed because mem_WE is gated by rst_n.
- Latency: grant to rsp_valid is 1 cycle. Throughput is 1 access per cycle back-to-back.
- Read-after-write to the same address in consecutive cycles returns the new data, because the write completes at the edge before the read.
- The lock takes effect in the cycle the loader is granted with ld_lock=1. Releasing ld_lock allows other ports to be granted in that same cycle.

## Structure
- Shared package mem_pkg: W, AW, port indices (PORT_LD=0, PORT_DATA=1, PORT_FETCH=2), FSM state encoding.
- One sub-module: rr_pick2, the combinational two-way round-robin picker (inputs: two requests, rr_last; outputs: one-hot grant). Everything else stays in mem_arbiter.

## Test plan
- Reset: hold rst_n=0 with all req_valid=1 -> req_ready=000, mem_WE=0. After release, rsp_valid=000 and rsp_rdata=0.
- Single read: fetch reads addr 0x0C holding 17'h00003 -> req_ready=100 the same cycle, then rsp_valid=100 and rsp_rdata=17'h00003 the next cycle.
- Data/fetch contention: both valid continuously for 4 cycles -> grants data, fetch, data, fetch.
- Loader priority: all three valid -> loader granted first. Data and fetch are stalled that cycle and rr_last is unchanged.
- Lock: loader writes 0x20..0x23 with ld_lock=1 and deasserts valid for one cycle in the middle -> data/fetch never granted during the bubble. Drop ld_lock -> data granted the same cycle.
- RAW and reset mid-op: data writes 17'h1ABCD to 0x40, fetch reads 0x40 the next cycle -> rsp_rdata=17'h1ABCD. Then assert rst_n=0 during a granted write -> mem_WE=0 and the location is unchanged.
